// File: rtl/timing_seq_pkg.sv
// Shared types, control-word bit map and power-up table contents for the timing sequencer.
package timing_seq_pkg;

   typedef enum logic [0:0] {StIdle, StRun} seq_state_e;

   localparam int unsigned CTRL_READ         = 0;
   localparam int unsigned CTRL_WRITE        = 1;
   localparam int unsigned CTRL_LAST_READ    = 2;
   localparam int unsigned CTRL_LAST_WRITE   = 3;
   localparam int unsigned CTRL_CHECK_INPUTS = 4;
   localparam int unsigned CTRL_CLEAR_CARRY  = 5;
   localparam int unsigned CTRL_RESETCNT_N   = 6;

   localparam int unsigned DEF_CTRL_W = 7;

   // Reproduces the contents of the fixed timing ROM this block replaces.
   function automatic logic [DEF_CTRL_W-1:0] default_table(input int unsigned addr);
      logic [DEF_CTRL_W-1:0] val;
      case (addr)
         98:       val = 7'h4E;
         99, 101:  val = 7'h45;
         104:      val = 7'h52;
         105, 107: val = 7'h51;
         110:      val = 7'h62;
         118, 119: val = 7'h00;
         default:  val = (addr % 2 == 1) ? 7'h41 : 7'h42;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/timing_sequencer_if.sv
// Control/config handshake bundle between top-level control and the timing sequencer.
interface timing_sequencer_if #(
   parameter int unsigned STEP_W = 6,
   parameter int unsigned CTRL_W = 7
);
   localparam int unsigned SLOT_W = STEP_W + 1;

   logic              start;
   logic              continuous;
   logic              hold;
   logic              stop;
   logic              cfg_we;
   logic [SLOT_W-1:0] cfg_addr;
   logic [CTRL_W-1:0] cfg_data;
   logic [CTRL_W-1:0] ctrl;
   logic [STEP_W-1:0] step;
   logic              phase;
   logic              busy;
   logic              done;
   logic              wrap;
   logic              cfg_err;

   modport master (
      output start, continuous, hold, stop, cfg_we, cfg_addr, cfg_data,
      input  ctrl, step, phase, busy, done, wrap, cfg_err
   );

   modport slave (
      input  start, continuous, hold, stop, cfg_we, cfg_addr, cfg_data,
      output ctrl, step, phase, busy, done, wrap, cfg_err
   );

endinterface

// File: rtl/timing_table.sv
// Run-time-writable control table: one synchronous write port, one combinational read port.
module timing_table
   import timing_seq_pkg::*;
#(
   parameter int unsigned SLOT_W = 7,
   parameter int unsigned CTRL_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [SLOT_W-1:0] waddr,
   input  logic [CTRL_W-1:0] wdata,
   input  logic [SLOT_W-1:0] raddr,
   output logic [CTRL_W-1:0] rdata
);
   localparam int unsigned NUM_SLOTS = 2 ** SLOT_W;

   logic [CTRL_W-1:0] rd_arr [NUM_SLOTS];

   // Entries carry their power-up value and are deliberately outside the reset domain.
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_entry
      logic [CTRL_W-1:0] entry_q = CTRL_W'(default_table(i));

      always_ff @(posedge clk) begin
         if (we && (waddr == SLOT_W'(i))) begin
            entry_q <= wdata;
         end
      end

      assign rd_arr[i] = entry_q;
   end

   assign rdata = rd_arr[raddr];

endmodule

// File: rtl/timing_sequencer.sv
// Step/phase sequencer emitting registered control words from a writable table,
// with start/stop/hold handshake and single-shot or continuous operation.
module timing_sequencer
   import timing_seq_pkg::*;
#(
   parameter int unsigned       STEP_W    = 6,
   parameter int unsigned       CTRL_W    = 7,
   parameter logic [CTRL_W-1:0] IDLE_CTRL = '0
) (
   input logic               clk,
   input logic               rst_n,
   timing_sequencer_if.slave bus
);
   localparam int unsigned       SLOT_W    = STEP_W + 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = '1;

   seq_state_e        state_q;
   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] next_slot;
   logic [CTRL_W-1:0] table_rd;
   logic              table_we;

   // Table is read at the slot being entered so ctrl lands in step with slot_q.
   always_comb begin
      next_slot = '0;
      if (state_q == StRun && slot_q != LAST_SLOT) begin
         next_slot = slot_q + SLOT_W'(1);
      end
      table_we = bus.cfg_we && (state_q == StIdle);
   end

   timing_table #(
      .SLOT_W (SLOT_W),
      .CTRL_W (CTRL_W)
   ) u_table (
      .clk   (clk),
      .we    (table_we),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_data),
      .raddr (next_slot),
      .rdata (table_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         slot_q      <= '0;
         bus.ctrl    <= IDLE_CTRL;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.wrap    <= 1'b0;
         bus.cfg_err <= 1'b0;
      end else begin
         bus.done    <= 1'b0;
         bus.wrap    <= 1'b0;
         bus.cfg_err <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start && !bus.stop) begin
                  state_q  <= StRun;
                  slot_q   <= '0;
                  bus.ctrl <= table_rd;
                  bus.busy <= 1'b1;
               end
            end
            StRun: begin
               bus.cfg_err <= bus.cfg_we;
               if (bus.stop) begin
                  state_q  <= StIdle;
                  slot_q   <= '0;
                  bus.ctrl <= IDLE_CTRL;
                  bus.busy <= 1'b0;
               end else if (!bus.hold) begin
                  if (slot_q != LAST_SLOT) begin
                     slot_q   <= next_slot;
                     bus.ctrl <= table_rd;
                  end else if (bus.continuous) begin
                     slot_q   <= '0;
                     bus.ctrl <= table_rd;
                     bus.wrap <= 1'b1;
                  end else begin
                     state_q  <= StIdle;
                     slot_q   <= '0;
                     bus.ctrl <= IDLE_CTRL;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.step  = slot_q[SLOT_W-1:1];
   assign bus.phase = slot_q[0];

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer: directed scenarios plus a randomized run,
// all compared against a run-position/array reference model.
module tb_timing_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   timing_sequencer_if #(.STEP_W(6), .CTRL_W(7)) bus ();

   timing_sequencer #(
      .STEP_W    (6),
      .CTRL_W    (7),
      .IDLE_CTRL (7'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: run flag, position within the 128-slot run, captured ctrl, table copy.
   bit         m_run;
   int         m_pos;
   logic [6:0] m_ctrl;
   bit         m_done;
   bit         m_wrap;
   bit         m_err;
   logic [6:0] m_mem [128];

   logic [17:0] dut_vec;
   assign dut_vec = {bus.ctrl, bus.step, bus.phase, bus.busy, bus.done, bus.wrap, bus.cfg_err};

   function automatic logic [17:0] exp_vec();
      logic [5:0] st;
      logic       ph;
      st = 6'(m_pos / 2);
      ph = 1'(m_pos % 2);
      return {m_ctrl, st, ph, m_run, m_done, m_wrap, m_err};
   endfunction

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_ctrl = 7'h00; m_done = 0; m_wrap = 0; m_err = 0;
   endtask

   task automatic model_edge();
      m_done = 0; m_wrap = 0; m_err = 0;
      if (!m_run) begin
         if (bus.start && !bus.stop) begin
            m_run = 1; m_pos = 0; m_ctrl = m_mem[0];
         end
         if (bus.cfg_we) m_mem[bus.cfg_addr] = bus.cfg_data;
      end else begin
         if (bus.cfg_we) m_err = 1;
         if (bus.stop) begin
            m_run = 0; m_pos = 0; m_ctrl = 7'h00;
         end else if (!bus.hold) begin
            if (m_pos == 127) begin
               if (bus.continuous) begin
                  m_pos = 0; m_ctrl = m_mem[0]; m_wrap = 1;
               end else begin
                  m_run = 0; m_pos = 0; m_ctrl = 7'h00; m_done = 1;
               end
            end else begin
               m_pos++;
               m_ctrl = m_mem[m_pos];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      model_reset();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", dut_vec, exp_vec());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_run();
      int busy_cnt = 0;
      int done_cnt = 0;
      bus.continuous = 1'b0;
      bus.start      = 1'b1;
      for (int i = 0; i < 135; i++) begin
         tick();
         if (i == 0) bus.start = 1'b0;
         busy_cnt += int'(bus.busy);
         done_cnt += int'(bus.done);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL single_run i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (i == 98) begin
            checks++;
            if (bus.ctrl !== 7'h4E) begin
               errors++;
               $display("FAIL slot98_ctrl got=%h want=4e", bus.ctrl);
            end
         end
         if (i == 118) begin
            checks++;
            if (bus.ctrl !== 7'h00) begin
               errors++;
               $display("FAIL slot118_ctrl got=%h want=00", bus.ctrl);
            end
         end
      end
      checks++;
      if (busy_cnt != 128 || done_cnt != 1 || bus.ctrl !== 7'h00) begin
         errors++;
         $display("FAIL single_run_len busy=%0d done=%0d ctrl=%h want busy=128 done=1 ctrl=00",
                  busy_cnt, done_cnt, bus.ctrl);
      end
   endtask

   task automatic test_continuous();
      int wraps    = 0;
      int done_cnt = 0;
      bus.continuous = 1'b1;
      bus.start      = 1'b1;
      for (int i = 0; i < 300 && wraps < 2; i++) begin
         tick();
         if (i == 0) bus.start = 1'b0;
         done_cnt += int'(bus.done);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL continuous i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (bus.wrap) begin
            wraps++;
            checks++;
            if (i != 128 * wraps || bus.step !== 6'd0 || bus.phase !== 1'b0
                || bus.ctrl !== 7'h42) begin
               errors++;
               $display("FAIL wrap_point i=%0d step=%0d ph=%b ctrl=%h want i=%0d step=0 ph=0 ctrl=42",
                        i, bus.step, bus.phase, bus.ctrl, 128 * wraps);
            end
         end
      end
      bus.stop = 1'b1;
      tick();
      bus.stop       = 1'b0;
      bus.continuous = 1'b0;
      checks++;
      if (wraps != 2 || done_cnt != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0
          || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL continuous_stop wraps=%0d done_cnt=%0d got=%h want wraps=2 done_cnt=0 %h",
                  wraps, done_cnt, dut_vec, exp_vec());
      end
   endtask

   task automatic test_hold();
      int busy_cnt = 0;
      bus.start = 1'b1;
      for (int i = 0; i < 145; i++) begin
         tick();
         if (i == 0)  bus.start = 1'b0;
         if (i == 40) bus.hold  = 1'b1;
         if (i == 45) bus.hold  = 1'b0;
         busy_cnt += int'(bus.busy);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL hold_run i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (i >= 41 && i <= 45) begin
            checks++;
            if (bus.step !== 6'd20 || bus.phase !== 1'b0 || bus.ctrl !== 7'h42) begin
               errors++;
               $display("FAIL hold_frozen i=%0d step=%0d ph=%b ctrl=%h want 20/0/42",
                        i, bus.step, bus.phase, bus.ctrl);
            end
         end
      end
      checks++;
      if (busy_cnt != 133) begin
         errors++;
         $display("FAIL hold_len busy=%0d want 133", busy_cnt);
      end
   endtask

   task automatic test_cfg();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 7'd3;
      bus.cfg_data = 7'h7F;
      tick();
      bus.cfg_we = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL cfg_idle_write got=%h want=%h", dut_vec, exp_vec());
      end
      bus.start = 1'b1;
      for (int i = 0; i < 135; i++) begin
         tick();
         if (i == 0) bus.start = 1'b0;
         if (i == 1) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 7'd3;
            bus.cfg_data = 7'h11;
         end
         if (i == 2) bus.cfg_we = 1'b0;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL cfg_run i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (i == 2) begin
            checks++;
            if (bus.cfg_err !== 1'b1) begin
               errors++;
               $display("FAIL cfg_err_pulse got=%b want=1", bus.cfg_err);
            end
         end
         if (i == 3) begin
            checks++;
            if (bus.ctrl !== 7'h7F) begin
               errors++;
               $display("FAIL cfg_slot3 got=%h want=7f", bus.ctrl);
            end
         end
      end
   endtask

   task automatic test_start_stop();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL start_stop_idle busy=%b got=%h want busy=0 %h", bus.busy, dut_vec, exp_vec());
      end
      bus.start = 1'b1;
      for (int i = 0; i < 135; i++) begin
         tick();
         if (i == 0)  bus.start = 1'b0;
         if (i == 50) bus.start = 1'b1;
         if (i == 51) bus.start = 1'b0;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL start_midrun i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (i == 52) begin
            checks++;
            if (bus.step !== 6'd26 || bus.phase !== 1'b0) begin
               errors++;
               $display("FAIL no_restart step=%0d ph=%b want 26/0", bus.step, bus.phase);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      bus.start = 1'b1;
      for (int i = 0; i <= 60; i++) begin
         tick();
         if (i == 0) bus.start = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.ctrl !== 7'h00 || bus.busy !== 1'b0 || bus.step !== 6'd0) begin
         errors++;
         $display("FAIL async_reset ctrl=%h busy=%b step=%0d want 00/0/0",
                  bus.ctrl, bus.busy, bus.step);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.start = 1'b1;
      for (int i = 0; i < 135; i++) begin
         tick();
         if (i == 0) bus.start = 1'b0;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset_run i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
         if (i == 3) begin
            checks++;
            if (bus.ctrl !== 7'h7F) begin
               errors++;
               $display("FAIL table_kept got=%h want=7f", bus.ctrl);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         bus.start = ($urandom_range(0, 7) == 0);
         bus.stop  = ($urandom_range(0, 99) == 0);
         bus.hold  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 63) == 0) bus.continuous = ~bus.continuous;
         bus.cfg_we   = ($urandom_range(0, 15) == 0);
         bus.cfg_addr = 7'($urandom_range(0, 127));
         bus.cfg_data = 7'($urandom_range(0, 127));
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random i=%0d got=%h want=%h", i, dut_vec, exp_vec());
         end
      end
      bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.cfg_we = 1'b0;
      bus.continuous = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.continuous = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      for (int i = 0; i < 128; i++) m_mem[i] = (i % 2 == 1) ? 7'h41 : 7'h42;
      m_mem[98]  = 7'h4E; m_mem[99]  = 7'h45; m_mem[101] = 7'h45;
      m_mem[104] = 7'h52; m_mem[105] = 7'h51; m_mem[107] = 7'h51;
      m_mem[110] = 7'h62; m_mem[118] = 7'h00; m_mem[119] = 7'h00;
      model_reset();

      test_reset();
      test_single_run();
      test_continuous();
      test_hold();
      test_cfg();
      test_start_stop();
      test_async_reset();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
